// File: rtl/word_frame_if.sv
// Word stream handshake between a payload source, the framer and the serializer path.
interface word_frame_if;
  logic [15:0] DIN;
  logic        DIPUSH;
  logic        DIFULL;
  logic [15:0] DOUT;
  logic        DOPUSH;
  logic        DOPULL;

  modport slave  (input DIN, DIPUSH, DOPULL, output DIFULL, DOUT, DOPUSH);
  modport master (output DIN, DIPUSH, DOPULL, input DIFULL, DOUT, DOPUSH);
endinterface

// File: rtl/word_frame.sv
// Transmit framer: sync-word training run, then header + FRAME_LEN payload words from a small FIFO.
// Define WORD_FRAME_CRC_EN to append a CRC-16-CCITT trailer word to every frame.
module word_frame #(
  parameter logic [15:0] SYNC_WORD = 16'h0FF0,
  parameter logic [7:0]  HDR_TAG   = 8'hA5,
  parameter int          TRAIN_LEN = 64,
  parameter int          FRAME_LEN = 256,
  parameter int          FIFO_AW   = 2
) (
  input  logic        CLK,
  input  logic        RSTX,
  input  logic        INIT,
  word_frame_if.slave bus,
  output logic        TRAINING,
  output logic [31:0] FRAME_CNT
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int TW    = $clog2(TRAIN_LEN + 1);
  localparam int WW    = $clog2(FRAME_LEN + 1);
  localparam logic [TW-1:0]      TRAIN_LAST = TW'(TRAIN_LEN - 1);
  localparam logic [WW-1:0]      WORD_LAST  = WW'(FRAME_LEN - 1);
  localparam logic [FIFO_AW:0]   FULL_FILL  = (FIFO_AW + 1)'(DEPTH);

`ifdef WORD_FRAME_CRC_EN
  typedef enum logic [1:0] {TRAIN, HDR, DATA, CRC} state_t;
`else
  typedef enum logic [1:0] {TRAIN, HDR, DATA} state_t;
`endif

  state_t             state;
  logic [TW-1:0]      train_cnt;
  logic [WW-1:0]      word_cnt;
  logic [7:0]         seq;
  logic [15:0]        dout;
  logic               dopush;
  logic               training;
  logic [31:0]        frame_cnt;
  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   fill;
  logic               empty, full, push, load, pop;
  logic [15:0]        head_word;

`ifdef WORD_FRAME_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction
`endif

  assign fill      = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (fill == FULL_FILL);
  assign push      = bus.DIPUSH & ~full;
  // Output register accepts a new word when empty or being drained this cycle.
  assign load      = ~dopush | bus.DOPULL;
  assign pop       = ~INIT & load & (state == DATA) & ~empty;
  assign head_word = mem[rd_ptr[FIFO_AW-1:0]];

  assign bus.DIFULL = full;
  assign bus.DOUT   = dout;
  assign bus.DOPUSH = dopush;
  assign TRAINING   = training;
  assign FRAME_CNT  = frame_cnt;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= bus.DIN;
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state     <= TRAIN;
      train_cnt <= '0;
      word_cnt  <= '0;
      seq       <= '0;
      dout      <= '0;
      dopush    <= 1'b0;
      training  <= 1'b1;
      frame_cnt <= '0;
`ifdef WORD_FRAME_CRC_EN
      crc       <= 16'hFFFF;
`endif
    end else if (INIT) begin
      // FIFO contents and the frame counter survive a restart.
      state     <= TRAIN;
      train_cnt <= '0;
      word_cnt  <= '0;
      seq       <= '0;
      dopush    <= 1'b0;
      training  <= 1'b1;
    end else if (load) begin
      case (state)
        TRAIN: begin
          dout     <= SYNC_WORD;
          dopush   <= 1'b1;
          training <= 1'b1;
          if (train_cnt == TRAIN_LAST) begin
            train_cnt <= '0;
            state     <= HDR;
          end else begin
            train_cnt <= train_cnt + 1'b1;
          end
        end
        HDR: begin
          dout     <= {HDR_TAG, seq};
          dopush   <= 1'b1;
          training <= 1'b0;
          seq      <= seq + 1'b1;
          word_cnt <= '0;
          state    <= DATA;
`ifdef WORD_FRAME_CRC_EN
          crc      <= 16'hFFFF;
`endif
        end
        DATA: begin
          if (!empty) begin
            dout   <= head_word;
            dopush <= 1'b1;
`ifdef WORD_FRAME_CRC_EN
            crc    <= crc_step(crc, head_word);
`endif
            if (word_cnt == WORD_LAST) begin
              word_cnt <= '0;
`ifdef WORD_FRAME_CRC_EN
              state    <= CRC;
`else
              frame_cnt <= frame_cnt + 1'b1;
              state     <= HDR;
`endif
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end else begin
            // Underrun stalls the frame rather than inserting filler.
            dopush <= 1'b0;
          end
        end
`ifdef WORD_FRAME_CRC_EN
        CRC: begin
          dout      <= crc;
          dopush    <= 1'b1;
          frame_cnt <= frame_cnt + 1'b1;
          state     <= HDR;
        end
`endif
        default: state <= TRAIN;
      endcase
    end
  end
endmodule

// File: tb/tb_word_frame.sv
// Directed bench for word_frame: training, framing, backpressure, INIT restart, seq wrap, optional CRC trailer.
module tb_word_frame;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        init0, init1;
  logic        trn0, trn1;
  logic [31:0] fc0, fc1;
  logic        pull;
  int          sel;
  int          checks, errors;

  always #5 clk = ~clk;

  word_frame_if if0 ();
  word_frame_if if1 ();

  word_frame #(.FRAME_LEN(4)) b0 (
    .CLK(clk), .RSTX(rst_n), .INIT(init0), .bus(if0), .TRAINING(trn0), .FRAME_CNT(fc0)
  );
  word_frame #(.FRAME_LEN(1)) b1 (
    .CLK(clk), .RSTX(rst_n), .INIT(init1), .bus(if1), .TRAINING(trn1), .FRAME_CNT(fc1)
  );

  logic [15:0] m_dout;
  logic        m_dopush, m_difull, m_train;
  logic [31:0] m_fcnt;

  always_comb begin
    if (sel == 1) begin
      m_dout = if1.DOUT; m_dopush = if1.DOPUSH; m_difull = if1.DIFULL; m_train = trn1; m_fcnt = fc1;
    end else begin
      m_dout = if0.DOUT; m_dopush = if0.DOPUSH; m_difull = if0.DIFULL; m_train = trn0; m_fcnt = fc0;
    end
  end

  typedef struct {
    logic [15:0] w;
    logic [31:0] fc;
  } xfer_t;
  xfer_t       q[$];
  logic [15:0] eq[$];
  logic [15:0] crc_acc;

  typedef struct {
    logic        push;
    logic [15:0] din;
    logic        pull;
    logic        exp_dopush;
    logic [15:0] exp_dout;
    logic        exp_difull;
  } vec_t;
  vec_t tbl [11];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_pull(input logic p);
    pull = p;
    if0.DOPULL = p;
    if1.DOPULL = p;
  endtask

  task automatic set_push(input logic p, input logic [15:0] d);
    if (sel == 1) begin
      if1.DIPUSH = p; if1.DIN = d;
    end else begin
      if0.DIPUSH = p; if0.DIN = d;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  // Runs ncyc cycles, recording transfers and pushing base+k whenever the FIFO has room.
  task automatic run(input int ncyc, input int npush, input logic [15:0] base);
    int pushed;
    pushed = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (m_dopush && pull) q.push_back('{m_dout, m_fcnt});
      if (!m_difull && pushed < npush) begin
        set_push(1'b1, base + 16'(pushed));
        pushed++;
      end else begin
        set_push(1'b0, 16'h0000);
      end
      tick;
    end
    set_push(1'b0, 16'h0000);
  endtask

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
      else              r = r << 1;
    end
    return r;
  endfunction

  task automatic e_sync(input int n);
    for (int i = 0; i < n; i++) eq.push_back(16'h0FF0);
  endtask

  task automatic e_hdr(input logic [7:0] s);
    eq.push_back({8'hA5, s});
    crc_acc = 16'hFFFF;
  endtask

  task automatic e_pay(input logic [15:0] w);
    eq.push_back(w);
    crc_acc = crc_ref(crc_acc, w);
  endtask

  task automatic e_end;
`ifdef WORD_FRAME_CRC_EN
    eq.push_back(crc_acc);
`endif
  endtask

  task automatic cmp_stream(input string name);
    logic [15:0] a;
    chk($sformatf("%s_len", name), 32'(q.size()), 32'(eq.size()));
    for (int i = 0; i < eq.size(); i++) begin
      a = (i < q.size()) ? q[i].w : 16'hDEAD;
      chk($sformatf("%s[%0d]", name, i), 32'(a), 32'(eq[i]));
    end
    q.delete();
    eq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; sel = 0;
    rst_n = 1'b0; init0 = 1'b0; init1 = 1'b0;
    if0.DIN = '0; if0.DIPUSH = 1'b0; if1.DIN = '0; if1.DIPUSH = 1'b0;
    set_pull(1'b0);

    tbl[0]  = '{1'b1, 16'h0101, 1'b0, 1'b1, 16'h0FF0, 1'b0};
    tbl[1]  = '{1'b1, 16'h0102, 1'b0, 1'b1, 16'h0FF0, 1'b0};
    tbl[2]  = '{1'b1, 16'h0103, 1'b0, 1'b1, 16'h0FF0, 1'b0};
    tbl[3]  = '{1'b1, 16'h0104, 1'b0, 1'b1, 16'h0FF0, 1'b1};
    tbl[4]  = '{1'b1, 16'h0105, 1'b0, 1'b1, 16'h0FF0, 1'b1};
    tbl[5]  = '{1'b1, 16'h0106, 1'b0, 1'b1, 16'h0FF0, 1'b1};
    tbl[6]  = '{1'b1, 16'h0107, 1'b0, 1'b1, 16'h0FF0, 1'b1};
    tbl[7]  = '{1'b1, 16'h0108, 1'b0, 1'b1, 16'h0FF0, 1'b1};
    tbl[8]  = '{1'b1, 16'h0109, 1'b0, 1'b1, 16'h0FF0, 1'b1};
    tbl[9]  = '{1'b1, 16'h010A, 1'b0, 1'b1, 16'h0FF0, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0FF0, 1'b1};

    repeat (2) tick;
    chk("rst_dout",   32'(m_dout),   32'h0);
    chk("rst_dopush", 32'(m_dopush), 32'h0);
    chk("rst_difull", 32'(m_difull), 32'h0);
    chk("rst_train",  32'(m_train),  32'h1);
    chk("rst_fcnt",   m_fcnt,        32'h0);

    // Training run with no payload available.
    set_pull(1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick;
      chk($sformatf("train_word%0d", i), {14'h0, m_dopush, m_train, m_dout}, {16'h0002 | 16'h0001, 16'h0FF0});
    end
    tick;
    chk("first_hdr", {14'h0, m_dopush, m_train, m_dout}, {16'h0002, 16'hA500});
    tick;
    chk("empty_stall_dopush", 32'(m_dopush), 32'h0);

    // Backpressure during training: FIFO fills to 4, further pushes dropped.
    set_pull(1'b0);
    do_reset;
    for (int i = 0; i < 11; i++) begin
      set_push(tbl[i].push, tbl[i].din);
      set_pull(tbl[i].pull);
      tick;
      chk($sformatf("tbl%0d_dopush", i), 32'(m_dopush), 32'(tbl[i].exp_dopush));
      chk($sformatf("tbl%0d_dout", i),   32'(m_dout),   32'(tbl[i].exp_dout));
      chk($sformatf("tbl%0d_difull", i), 32'(m_difull), 32'(tbl[i].exp_difull));
    end
    set_push(1'b0, 16'h0000);
    run(90, 0, 16'h0000);
    e_sync(63); e_hdr(8'h00);
    e_pay(16'h0101); e_pay(16'h0102); e_pay(16'h0103); e_pay(16'h0104); e_end;
    e_hdr(8'h01);
    cmp_stream("stall_stream");
    chk("stall_difull_end", 32'(m_difull), 32'h0);
    chk("stall_fcnt", m_fcnt, 32'd1);

    // Two frames of four words with continuous pushing.
    do_reset;
    run(130, 8, 16'h0001);
    e_sync(64);
    e_hdr(8'h00); for (int i = 1; i <= 4; i++) e_pay(16'(i)); e_end;
    e_hdr(8'h01); for (int i = 5; i <= 8; i++) e_pay(16'(i)); e_end;
    e_hdr(8'h02);
    cmp_stream("two_frames");
    chk("two_frames_fcnt", m_fcnt, 32'd2);

    // INIT pulse while payload word 2 is on the output.
    set_pull(1'b0);
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 16'h0201 + 16'(i));
      tick;
    end
    set_push(1'b0, 16'h0000);
    set_pull(1'b1);
    for (int k = 0; k < 10; k++) begin
      if (m_dopush && m_dout == 16'h0202) break;
      tick;
    end
    chk("init_wait_word2", {15'h0, m_dopush, m_dout}, {16'h0001, 16'h0202});
    init0 = 1'b1;
    tick;
    init0 = 1'b0;
    chk("init_dopush", 32'(m_dopush), 32'h0);
    chk("init_train",  32'(m_train),  32'h1);
    run(80, 0, 16'h0000);
    e_sync(64); e_hdr(8'h00); e_pay(16'h0203); e_pay(16'h0204);
    cmp_stream("after_init");
    chk("init_fcnt_kept", m_fcnt, 32'd2);

    // Asynchronous reset with words buffered: everything cleared, FIFO discarded.
    set_pull(1'b0);
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 16'h0301 + 16'(i));
      tick;
    end
    set_push(1'b0, 16'h0000);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_dopush", 32'(m_dopush), 32'h0);
    chk("arst_dout",   32'(m_dout),   32'h0);
    chk("arst_difull", 32'(m_difull), 32'h0);
    chk("arst_train",  32'(m_train),  32'h1);
    chk("arst_fcnt",   m_fcnt,        32'h0);
    tick;
    rst_n = 1'b1;
    set_pull(1'b1);
    repeat (66) tick;
    chk("arst_fifo_dropped", {15'h0, m_dopush, m_dout}, {16'h0000, 16'hA500});

    // 256 one-word frames: sequence number wraps, frame count reaches 256.
    sel = 1;
    do_reset;
    run(1100, 256, 16'h0000);
`ifdef WORD_FRAME_CRC_EN
    chk("crc_first_pay_fcnt", (q.size() > 66) ? q[65].fc : 32'hFFFF_FFFF, 32'd0);
    chk("crc_trailer_zero",   (q.size() > 66) ? 32'(q[66].w) : 32'hFFFF_FFFF, 32'h1D0F);
    chk("crc_trailer_fcnt",   (q.size() > 66) ? q[66].fc : 32'hFFFF_FFFF, 32'd1);
`else
    chk("first_pay_fcnt", (q.size() > 65) ? q[65].fc : 32'hFFFF_FFFF, 32'd1);
`endif
    e_sync(64);
    for (int k = 0; k < 256; k++) begin
      e_hdr(8'(k));
      e_pay(16'(k));
      e_end;
    end
    e_hdr(8'h00);
    cmp_stream("wrap_stream");
    chk("wrap_fcnt", m_fcnt, 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/word_frame.md
Name: word_frame

Overview:
- Transmit-side framer feeding the 16-bit parallel path ahead of the serializer.
- Emits a training run of sync words so the far-end word aligner can lock.
- Then emits frames: one header word (tag plus sequence number), followed by FRAME_LEN payload words taken from a small input FIFO.
- It is the sending counterpart of the receive-side word aligner and checker.

Parameters:
- SYNC_WORD, 16'h0FF0, training word; rotation-unique pattern the aligner locks on.
- HDR_TAG, 8'hA5, upper byte of every frame header word.
- TRAIN_LEN, 64, number of SYNC_WORD transfers after reset or INIT (must be >= 1).
- FRAME_LEN, 256, payload words per frame (must be >= 1).
- FIFO_AW, 2, input FIFO address width; depth = 2**FIFO_AW.

Ports:
- CLK  input  1  single clock for all logic.
- RSTX  input  1  asynchronous active-low reset.
- INIT  input  1  synchronous level; while 1, holds the block in training and restarts the sequence.
- DIN  input  16  payload word.
- DIPUSH  input  1  DIN is written into the FIFO this cycle; ignored when DIFULL=1.
- DIFULL  output  1  FIFO full; the source must not push.
- DOUT  output  16  registered output word.
- DOPUSH  output  1  DOUT holds a valid word.
- DOPULL  input  1  downstream accepts DOUT this cycle.
- TRAINING  output  1  1 while in the TRAIN state.
- FRAME_CNT  output  32  count of completed frames; wraps at 2**32.

Behaviour:
Reset values:
- DOUT=0, DOPUSH=0, DIFULL=0, TRAINING=1, FRAME_CNT=0.
- FIFO empty, state=TRAIN, train count=0, seq=0, word count=0.

Output register:
- A transfer occurs when DOPUSH & DOPULL.
- The register loads a new word when !DOPUSH | DOPULL. Otherwise DOUT and DOPUSH hold, so the stall is lossless.

FIFO:
- Registered write; pointers are FIFO_AW+1 bits wide.
- DIFULL = (fill count == depth).
- Simultaneous push and pop when full: the push is refused, because DIFULL is asserted, and the pop proceeds.
- Push and pop when empty: the word cannot bypass the FIFO; it becomes visible the next cycle.
- Minimum latency from DIPUSH to DOPUSH with that word is 2 cycles.

State machine (advances only on a load of the output register):
- TRAIN: load SYNC_WORD. After TRAIN_LEN loads, go to HDR.
- HDR: load {HDR_TAG, seq[7:0]}, then seq++ (8-bit wrap 255 -> 0). Go to DATA with word count = 0.
- DATA:
  - If the FIFO is non-empty: pop, load the word, word count++.
  - If the FIFO is empty: load nothing, DOPUSH=0. An empty FIFO stalls the frame; no filler word is emitted.
  - When word count reaches FRAME_LEN: FRAME_CNT++ in the same cycle as the last payload load, then go to HDR (or CRC, see Optional Feature).

INIT:
- INIT=1 at any time, including mid-frame:
  - next state = TRAIN; train count, seq and word count clear; DOPUSH is forced 0 the following cycle.
  - FIFO contents and FRAME_CNT are preserved.
- While INIT stays 1, no words are loaded.
- Training starts on the first cycle after INIT falls.

Reset mid-operation:
- Every register returns to its reset value immediately (asynchronous).
- FIFO contents are discarded.

Optional Feature:
- Macro: WORD_FRAME_CRC_EN.
- Defined:
  - After the last payload word of a frame, the state goes to CRC.
  - CRC loads the CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no final XOR) of that frame's FRAME_LEN payload words, then goes to HDR.
  - The CRC register re-initialises on entry to DATA.
  - FRAME_CNT increments on the CRC load instead of on the last payload load.
- Undefined: no CRC state or logic; DATA goes directly to HDR.

Test Plan:
- Reset, INIT=0, DOPULL=1, no pushes -> 64 consecutive DOPUSH cycles with DOUT=16'h0FF0 and TRAINING=1, then DOUT=16'hA500 with TRAINING=0, then DOPUSH=0.
- FRAME_LEN=4, push 16'h0001..16'h0008 continuously -> DOUT sequence after training: A500, 0001, 0002, 0003, 0004, A501, 0005..0008; FRAME_CNT=2.
- Push while DOPULL=0 for 10 cycles -> DIFULL=1 after 4 accepted words; the 5th and later pushes are dropped; DOUT holds stable; after releasing DOPULL, exactly those 4 words appear in order.
- INIT pulse of 1 cycle during payload word 2 of a frame -> DOPUSH=0 the next cycle, then 64 sync words, then header A500 (seq restarted); buffered FIFO words follow the header.
- 256 frames at FRAME_LEN=1 -> header low byte wraps FF -> 00; FRAME_CNT=256.
- WORD_FRAME_CRC_EN, FRAME_LEN=1, payload 16'h0000 -> trailer word = CRC-CCITT(0xFFFF init) of 0x0000 = 16'h1D0F; FRAME_CNT increments on the trailer.
